// File: rtl/syscall_fetch_unit_pkg.sv
// Shared syscall definitions: trigger opcode, register indices, service
// codes and the FSM state encoding (the executor uses the same enum).
package syscall_pkg;

  localparam logic [5:0]  SYSCALL_OP    = 6'b011001;
  localparam logic [4:0]  V0_IDX        = 5'd2;
  localparam logic [4:0]  A0_IDX        = 5'd4;

  localparam logic [31:0] SVC_PRINT_INT = 32'd1;
  localparam logic [31:0] SVC_EXIT      = 32'd10;
  localparam logic [31:0] SVC_SPACE     = 32'd11;

  typedef enum logic [2:0] {
    IDLE, RD_V0, RD_A0, CAP, ISSUE, HALTED
  } state_t;

  // Services the executor knows how to run
  function automatic logic svc_supported(input logic [31:0] code);
    return (code == SVC_PRINT_INT) || (code == SVC_EXIT) || (code == SVC_SPACE);
  endfunction

endpackage

// File: rtl/syscall_fetch_unit.sv
// Syscall fetch unit: stalls on SYSCALL, reads $v0/$a0 through a spare
// register-file port, hands {code, arg} to the executor over valid/ready.
// Optional macro SYSCALL_COUNT_EN adds the svc_count port and counter.
//
// done and bad_svc are registered pulses. A bad code is recognised while
// $v0 is on rf_rdata, so bad_svc/done show up in CAP. After an accepted
// non-exit service the FSM spends one extra cycle in ISSUE with
// svc_valid low and done high, so the done cycle is still stalled and a
// syscall presented then is ignored; IDLE follows.
module syscall_fetch_unit
  import syscall_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [5:0]  opcode,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        stall,
  output logic        svc_valid,
  input  logic        svc_ready,
  output logic [31:0] svc_code,
  output logic [31:0] svc_arg,
  output logic        done,
  output logic        halted,
  output logic        bad_svc
`ifdef SYSCALL_COUNT_EN
  ,
  output logic [31:0] svc_count
`endif
);

  state_t state;
  logic   detect;

  assign detect = !rst && instr_valid && (opcode == SYSCALL_OP) && (state == IDLE);

  // Stall on detect, while the sequence runs, and forever once halted
  always_comb begin
    stall = detect || ((state != IDLE) && (state != HALTED)) || halted;
  end

  // Read-port address follows the read states; rdata lags one cycle
  always_comb begin
    rf_raddr = 5'd0;
    case (state)
      RD_V0:   rf_raddr = V0_IDX;
      RD_A0:   rf_raddr = A0_IDX;
      default: rf_raddr = 5'd0;
    endcase
  end

  // Main FSM with capture registers and registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      svc_valid <= 1'b0;
      svc_code  <= 32'd0;
      svc_arg   <= 32'd0;
      done      <= 1'b0;
      halted    <= 1'b0;
      bad_svc   <= 1'b0;
    end else begin
      done    <= 1'b0;
      bad_svc <= 1'b0;
      case (state)
        IDLE:  if (detect) state <= RD_V0;
        RD_V0: state <= RD_A0;
        RD_A0: begin
          // rf_rdata now carries $v0
          svc_code <= rf_rdata;
          state    <= CAP;
          if (!svc_supported(rf_rdata)) begin
            bad_svc <= 1'b1;
            done    <= 1'b1;
          end
        end
        CAP: begin
          // rf_rdata now carries $a0; bad codes retire here as a NOP
          svc_arg <= rf_rdata;
          if (bad_svc) begin
            state <= IDLE;
          end else begin
            state     <= ISSUE;
            svc_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (svc_valid && svc_ready) begin
            svc_valid <= 1'b0;
            if (svc_code == SVC_EXIT) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else if (done) begin
            // done cycle is over; let decode advance
            state <= IDLE;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYSCALL_COUNT_EN
  // Count accepted services (exit included, bad codes excluded); wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         svc_count <= 32'd0;
    else if (svc_valid && svc_ready) svc_count <= svc_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_syscall_fetch_unit.sv
// Bench for syscall_fetch_unit: register file model, directed scenarios
// and randomized syscalls checked against cycle offsets from detect.
module tb_syscall_fetch_unit;
  import syscall_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata = 32'd0;
  logic        stall, svc_valid, svc_ready = 1'b0;
  logic [31:0] svc_code, svc_arg;
  logic        done, halted, bad_svc;
`ifdef SYSCALL_COUNT_EN
  logic [31:0] svc_count;
`endif

  logic [31:0] regs [32];
  int total = 0, passed = 0, fails = 0;
  int exp_cnt = 0;

  syscall_fetch_unit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .stall(stall),
    .svc_valid(svc_valid), .svc_ready(svc_ready), .svc_code(svc_code),
    .svc_arg(svc_arg), .done(done), .halted(halted), .bad_svc(bad_svc)
`ifdef SYSCALL_COUNT_EN
    , .svc_count(svc_count)
`endif
  );

  always #5 clk = ~clk;

  // Register file: one-cycle read latency
  always @(posedge clk) rf_rdata <= regs[rf_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic good_code(input logic [31:0] c);
    return c == 32'd1 || c == 32'd10 || c == 32'd11;
  endfunction

  // One syscall: detect at t=0, reads at t=1..3, issue from t=4 with
  // svc_ready held low for wait_n cycles; done one cycle after acceptance.
  task automatic run_sc(input logic [31:0] code, input logic [31:0] arg, input int wait_n);
    regs[2] = code;
    regs[4] = arg;
    step();
    instr_valid = 1'b1; opcode = SYSCALL_OP; svc_ready = 1'b0;
    #1 chk("t0 stall", stall, 1); chk("t0 valid", svc_valid, 0);
    for (int t = 1; t <= 3; t++) begin
      step(); #1;
      chk("rd stall", stall, 1);
      chk("rd valid", svc_valid, 0);
      chk("rd bad", bad_svc, (t == 3 && !good_code(code)));
      chk("rd done", done, (t == 3 && !good_code(code)));
    end
    if (!good_code(code)) begin
      step(); instr_valid = 1'b0; #1;
      chk("bad release stall", stall, 0);
      chk("bad done clr", done, 0);
      chk("bad valid", svc_valid, 0);
      return;
    end
    for (int k = 0; k <= wait_n; k++) begin
      step(); svc_ready = (k == wait_n); #1;
      chk("iss valid", svc_valid, 1);
      chk("iss code", svc_code, code);
      chk("iss arg", svc_arg, arg);
      chk("iss done", done, 0);
      chk("iss stall", stall, 1);
    end
    exp_cnt++;
    step(); svc_ready = 1'b0; #1;
    chk("acc valid", svc_valid, 0);
    chk("acc stall", stall, 1);
    if (code == SVC_EXIT) begin
      chk("exit halted", halted, 1);
      chk("exit no done", done, 0);
    end else begin
      chk("acc done", done, 1);
      step(); instr_valid = 1'b0; #1;
      chk("post done", done, 0);
      chk("post stall", stall, 0);
    end
  endtask

  initial begin
    logic [31:0] c;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;

    rst = 1'b1; #12;
    chk("rst stall", stall, 0); chk("rst valid", svc_valid, 0);
    chk("rst done", done, 0); chk("rst halted", halted, 0);
    chk("rst bad", bad_svc, 0); chk("rst code", svc_code, 0);
    chk("rst arg", svc_arg, 0); chk("rst raddr", rf_raddr, 0);
    @(negedge clk); rst = 1'b0;

    run_sc(32'd1, 32'hFFFF_FFF6, 0);   // print-int
    run_sc(32'd11, 32'h1234_5678, 6);  // space with backpressure
    run_sc(32'd7, 32'hDEAD_BEEF, 0);   // unsupported code

    // non-syscall opcode must not trigger
    step(); instr_valid = 1'b1; opcode = 6'b000000; #1;
    chk("nop stall", stall, 0);
    step(); instr_valid = 1'b0; #1;
    chk("nop valid", svc_valid, 0);

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 2))
        0: c = 32'd1;
        1: c = 32'd11;
        default: begin
          c = $urandom;
          if (good_code(c)) c = 32'd99;
        end
      endcase
      run_sc(c, $urandom, $urandom_range(0, 3));
    end
`ifdef SYSCALL_COUNT_EN
    chk("svc_count", svc_count, exp_cnt);
`endif

    // reset while in RD_A0 aborts the sequence
    regs[2] = 32'd1; regs[4] = 32'd5;
    step(); instr_valid = 1'b1; opcode = SYSCALL_OP;
    step(); step(); instr_valid = 1'b0;
    #2 rst = 1'b1; #1;
    chk("mrst stall", stall, 0); chk("mrst valid", svc_valid, 0);
    chk("mrst done", done, 0); chk("mrst raddr", rf_raddr, 0);
    chk("mrst code", svc_code, 0);
    @(negedge clk); rst = 1'b0; exp_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(); #1;
      chk("mrst no valid", svc_valid, 0);
      chk("mrst no done", done, 0);
    end
`ifdef SYSCALL_COUNT_EN
    chk("mrst count", svc_count, 0);
`endif

    // exit then further syscalls are ignored
    run_sc(32'd10, 32'd0, 2);
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      chk("halt valid", svc_valid, 0);
      chk("halt sticky", halted, 1);
      chk("halt stall", stall, 1);
      chk("halt done", done, 0);
    end
`ifdef SYSCALL_COUNT_EN
    chk("exit count", svc_count, exp_cnt);
`endif
    instr_valid = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk("clr halted", halted, 0); chk("clr stall", stall, 0);
    @(negedge clk); rst = 1'b0;
    step(); #1;
    chk("after rst halted", halted, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
